// File: rtl/buffer_pingpong_ctrl_pkg.sv
// Shared types and constants for the two-bank ping-pong SRAM buffer controller.
package garuda_buf_pkg;

    localparam int BUF_NUM_BANKS  = 2;
    localparam int BUF_DEPTH      = 4096;
    localparam int BUF_DATA_WIDTH = 32;
    localparam int BUF_AW         = $clog2(BUF_DEPTH);

    // Fill length: one bit wider than an address so a full bank of DEPTH words fits.
    typedef logic [BUF_AW:0] buf_len_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/buffer_pingpong_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; after a contested cycle the loser gets priority.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic prio_q;
    logic prio_d;

    // Grant selection and priority update; prio_q == 1 favours requester 1.
    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                gnt_o  = prio_q ? 2'b10 : 2'b01;
                prio_d = ~prio_q;
            end
            default: gnt_o = 2'b00;
        endcase
    end

    // Priority register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/buffer_pingpong_ctrl.sv
// Ping-pong sequencer for a two-bank SRAM: producer fills one bank while the consumer reads the other,
// sharing one bank select through a round-robin arbiter.
module buffer_pingpong_ctrl
    import garuda_buf_pkg::*;
#(
    parameter int DEPTH      = BUF_DEPTH,
    parameter int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter int NUM_BANKS  = BUF_NUM_BANKS
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         prod_start_i,
    input  logic [$clog2(DEPTH):0]       prod_len_i,
    input  logic                         prod_valid_i,
    input  logic [DATA_WIDTH-1:0]        prod_data_i,
    output logic                         prod_ready_o,
    output logic                         prod_start_err_o,
    output logic                         fill_done_o,
    output logic                         cons_avail_o,
    output logic [$clog2(DEPTH):0]       cons_len_o,
    input  logic                         cons_req_i,
    input  logic [$clog2(DEPTH)-1:0]     cons_addr_i,
    output logic                         cons_gnt_o,
    output logic [DATA_WIDTH-1:0]        cons_data_o,
    output logic                         cons_oob_o,
    input  logic                         cons_release_i,
    output logic                         buf_wr_en_o,
    output logic [$clog2(DEPTH)-1:0]     buf_wr_addr_o,
    output logic [DATA_WIDTH-1:0]        buf_wr_data_o,
    output logic                         buf_rd_en_o,
    output logic [$clog2(DEPTH)-1:0]     buf_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]        buf_rd_data_i,
    output logic                         buf_bank_sel_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LEN_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LEN_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] CNT_ONE   = {{(AW-1){1'b0}}, 1'b1};

    if (NUM_BANKS != BUF_NUM_BANKS) begin : g_num_banks_chk
        $error("buffer_pingpong_ctrl supports exactly two banks");
    end

    bank_state_e     bank_q [NUM_BANKS];
    bank_state_e     bank_d [NUM_BANKS];
    logic [AW:0]     len_q  [NUM_BANKS];
    logic [AW:0]     len_d  [NUM_BANKS];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic            any_filling_s;
    logic            avail_s;
    logic            len_ok_s;
    logic            start_ok_s;
    logic            release_s;
    logic            last_beat_s;
    logic            wr_gnt_s;
    logic            rd_gnt_s;
    logic            oob_s;
    logic            rd_en_s;
    logic [1:0]      req_s;
    logic [1:0]      gnt_s;

    // Request decode and start/release qualification from pre-edge state.
    always_comb begin
        any_filling_s = (bank_q[0] == FILLING) || (bank_q[1] == FILLING);
        avail_s       = (bank_q[rd_ptr_q] == FULL);
        len_ok_s      = (prod_len_i != {(AW+1){1'b0}}) && (prod_len_i <= LEN_DEPTH);
        start_ok_s    = prod_start_i && !any_filling_s && (bank_q[wr_ptr_q] == EMPTY) && len_ok_s;
        release_s     = cons_release_i && avail_s;
        req_s[0]      = prod_valid_i && (bank_q[wr_ptr_q] == FILLING);
        req_s[1]      = cons_req_i && avail_s;
    end

    rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_s),
        .gnt_o  (gnt_s)
    );

    // Next-state: fill sequencing on the write bank, release on the read bank.
    always_comb begin
        wr_gnt_s    = gnt_s[0];
        rd_gnt_s    = gnt_s[1];
        bank_d      = bank_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        last_beat_s = wr_gnt_s && ({1'b0, cnt_q} == (len_q[wr_ptr_q] - LEN_ONE));
        err_d       = prod_start_i && !start_ok_s;
        done_d      = last_beat_s;
        if (start_ok_s) begin
            bank_d[wr_ptr_q] = FILLING;
            len_d[wr_ptr_q]  = prod_len_i;
            cnt_d            = {AW{1'b0}};
        end else if (wr_gnt_s) begin
            cnt_d = cnt_q + CNT_ONE;
            if (last_beat_s) begin
                bank_d[wr_ptr_q] = FULL;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
        // The released bank is never the write bank, so this cannot collide with the fill update.
        if (release_s) begin
            bank_d[rd_ptr_q] = EMPTY;
            rd_ptr_d         = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= EMPTY;
                len_q[b]  <= {(AW+1){1'b0}};
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= {AW{1'b0}};
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            bank_q   <= bank_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Output muxing; address/data buses are held at zero when their strobe is low.
    always_comb begin
        cons_avail_o     = avail_s;
        cons_len_o       = avail_s ? len_q[rd_ptr_q] : {(AW+1){1'b0}};
        oob_s            = rd_gnt_s && ({1'b0, cons_addr_i} >= cons_len_o);
        rd_en_s          = rd_gnt_s && !oob_s;
        prod_ready_o     = wr_gnt_s;
        buf_wr_en_o      = wr_gnt_s;
        buf_wr_addr_o    = wr_gnt_s ? cnt_q : {AW{1'b0}};
        buf_wr_data_o    = wr_gnt_s ? prod_data_i : {DATA_WIDTH{1'b0}};
        cons_gnt_o       = rd_gnt_s;
        cons_oob_o       = oob_s;
        buf_rd_en_o      = rd_en_s;
        buf_rd_addr_o    = rd_en_s ? cons_addr_i : {AW{1'b0}};
        cons_data_o      = rd_en_s ? buf_rd_data_i : {DATA_WIDTH{1'b0}};
        buf_bank_sel_o   = rd_gnt_s ? rd_ptr_q : wr_ptr_q;
        prod_start_err_o = err_q;
        fill_done_o      = done_q;
    end

endmodule

// File: tb/tb_buffer_pingpong_ctrl.sv
// Self-checking bench: directed steps plus random traffic against a queue-based model of bank hand-off.
module tb_buffer_pingpong_ctrl;
    import garuda_buf_pkg::*;

    localparam int DEPTH = 4096;
    localparam int DW    = 32;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          prod_start, prod_valid, prod_ready, start_err, fill_done;
    buf_len_t      prod_len;
    logic [DW-1:0] prod_data;
    logic          cons_avail, cons_req, cons_gnt, cons_oob, cons_release;
    logic [AW:0]   cons_len;
    logic [AW-1:0] cons_addr;
    logic [DW-1:0] cons_data;
    logic          buf_wr_en, buf_rd_en, buf_bank_sel;
    logic [AW-1:0] buf_wr_addr, buf_rd_addr;
    logic [DW-1:0] buf_wr_data, buf_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffer_pingpong_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .prod_start_i(prod_start), .prod_len_i(prod_len), .prod_valid_i(prod_valid),
        .prod_data_i(prod_data), .prod_ready_o(prod_ready), .prod_start_err_o(start_err),
        .fill_done_o(fill_done), .cons_avail_o(cons_avail), .cons_len_o(cons_len),
        .cons_req_i(cons_req), .cons_addr_i(cons_addr), .cons_gnt_o(cons_gnt),
        .cons_data_o(cons_data), .cons_oob_o(cons_oob), .cons_release_i(cons_release),
        .buf_wr_en_o(buf_wr_en), .buf_wr_addr_o(buf_wr_addr), .buf_wr_data_o(buf_wr_data),
        .buf_rd_en_o(buf_rd_en), .buf_rd_addr_o(buf_rd_addr), .buf_rd_data_i(buf_rd_data),
        .buf_bank_sel_o(buf_bank_sel)
    );

    // SRAM environment: synchronous write, asynchronous read.
    logic [DW-1:0] sram [2*DEPTH];
    assign buf_rd_data = sram[{buf_bank_sel, buf_rd_addr}];
    always @(posedge clk) if (buf_wr_en) sram[{buf_bank_sel, buf_wr_addr}] <= buf_wr_data;

    // Reference model: FIFO of full banks (front = readable), one optional active fill.
    int            full_bank_q[$];
    int            full_len_q[$];
    logic [DW-1:0] ref_mem [2][DEPTH];
    bit            fill_active;
    int            fill_len, fill_cnt, next_bank;
    bit            prio_cons;
    bit            exp_err, exp_done, exp_wg, exp_rg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        full_bank_q.delete();
        full_len_q.delete();
        fill_active = 1'b0;
        fill_len = 0; fill_cnt = 0; next_bank = 0;
        prio_cons = 1'b0; exp_err = 1'b0; exp_done = 1'b0;
    endtask

    function automatic bit bank_busy(input int b);
        foreach (full_bank_q[i]) if (full_bank_q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        prod_start = 1'b0; prod_len = '0; prod_valid = 1'b0; prod_data = '0;
        cons_req = 1'b0; cons_addr = '0; cons_release = 1'b0;
    endtask

    task automatic check_outputs();
        bit wr_req, rd_req, avail, oob, rd_en;
        int rlen, rbank;
        avail  = (full_bank_q.size() > 0);
        rlen   = avail ? full_len_q[0] : 0;
        rbank  = avail ? full_bank_q[0] : 0;
        wr_req = prod_valid && fill_active;
        rd_req = cons_req && avail;
        exp_wg = wr_req && (!rd_req || !prio_cons);
        exp_rg = rd_req && (!wr_req || prio_cons);
        oob    = exp_rg && (int'(cons_addr) >= rlen);
        rd_en  = exp_rg && !oob;
        chk("prod_ready", prod_ready, exp_wg);
        chk("buf_wr_en", buf_wr_en, exp_wg);
        if (exp_wg) begin
            chk("buf_wr_addr", buf_wr_addr, fill_cnt);
            chk("buf_wr_data", buf_wr_data, prod_data);
        end
        chk("cons_avail", cons_avail, avail);
        chk("cons_len", cons_len, rlen);
        chk("cons_gnt", cons_gnt, exp_rg);
        chk("cons_oob", cons_oob, oob);
        chk("buf_rd_en", buf_rd_en, rd_en);
        if (rd_en) chk("buf_rd_addr", buf_rd_addr, cons_addr);
        chk("cons_data", cons_data, rd_en ? ref_mem[rbank][cons_addr] : '0);
        chk("buf_bank_sel", buf_bank_sel, exp_rg ? rbank : next_bank);
        chk("start_err", start_err, exp_err);
        chk("fill_done", fill_done, exp_done);
    endtask

    task automatic model_edge();
        bit avail, start_ok;
        avail    = (full_bank_q.size() > 0);
        start_ok = prod_start && !fill_active && !bank_busy(next_bank)
                   && (prod_len >= 1) && (prod_len <= DEPTH);
        exp_err  = prod_start && !start_ok;
        exp_done = 1'b0;
        if (prod_valid && fill_active && cons_req && avail) prio_cons = exp_wg;
        if (cons_release && avail) begin
            void'(full_bank_q.pop_front());
            void'(full_len_q.pop_front());
        end
        if (start_ok) begin
            fill_active = 1'b1; fill_len = int'(prod_len); fill_cnt = 0;
        end
        if (exp_wg) begin
            ref_mem[next_bank][fill_cnt] = prod_data;
            fill_cnt++;
            if (fill_cnt == fill_len) begin
                full_bank_q.push_back(next_bank);
                full_len_q.push_back(fill_len);
                fill_active = 1'b0;
                next_bank ^= 1;
                exp_done = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, prod_ready, 0);
        chk({tag, "_err"}, start_err, 0);
        chk({tag, "_done"}, fill_done, 0);
        chk({tag, "_avail"}, cons_avail, 0);
        chk({tag, "_len"}, cons_len, 0);
        chk({tag, "_gnt"}, cons_gnt, 0);
        chk({tag, "_data"}, cons_data, 0);
        chk({tag, "_oob"}, cons_oob, 0);
        chk({tag, "_wr_en"}, buf_wr_en, 0);
        chk({tag, "_rd_en"}, buf_rd_en, 0);
        chk({tag, "_sel"}, buf_bank_sel, 0);
    endtask

    initial begin
        int cyc;
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: fill bank0 with 4 back-to-back beats
        prod_start = 1'b1; prod_len = 4; tick(); prod_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            prod_valid = 1'b1; prod_data = $urandom; tick();
        end
        prod_valid = 1'b0;
        chk("t1_fill_done", fill_done, 1);
        chk("t1_avail", cons_avail, 1);
        chk("t1_len", cons_len, 4);
        tick();

        // 2: fill bank1 (len 3) under constant read contention
        prod_start = 1'b1; prod_len = 3; tick(); prod_start = 1'b0;
        cyc = 0;
        do begin
            prod_valid = 1'b1; prod_data = $urandom;
            cons_req = 1'b1; cons_addr = AW'($urandom_range(0, 3));
            tick(); cyc++;
        end while (!fill_done && cyc < 12);
        chk("t2_fill_cycles_le6", (fill_done && cyc <= 6), 1);
        idle(); tick();

        // 4 and 3: both full -> reject; release; length/while-filling rejections; accept on bank0
        prod_start = 1'b1; prod_len = 2; tick();
        chk("t4_start_both_full_err", start_err, 1);
        idle(); cons_release = 1'b1; tick(); cons_release = 1'b0;
        chk("t4_rd_ptr1_len", cons_len, 3);
        prod_start = 1'b1; prod_len = 0; tick();
        chk("t3_len0_err", start_err, 1);
        prod_len = DEPTH + 1; tick();
        chk("t3_len_over_err", start_err, 1);
        prod_len = 2; tick();
        chk("t4_start_ok", start_err, 0);
        prod_len = 1; tick();
        chk("t3_while_filling_err", start_err, 1);
        idle();
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1; prod_data = $urandom; tick();
        end
        idle(); tick();

        // 5: out-of-bounds read of bank1 (len 3)
        cons_req = 1'b1; cons_addr = 5; #1;
        chk("t5_gnt", cons_gnt, 1);
        chk("t5_oob", cons_oob, 1);
        chk("t5_data", cons_data, 0);
        chk("t5_rd_en", buf_rd_en, 0);
        tick(); idle();

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            int r;
            r = $urandom_range(0, 9);
            prod_start   = ($urandom_range(0, 7) == 0);
            prod_len     = (r == 0) ? '0 : (r == 1) ? buf_len_t'(DEPTH + 1) : buf_len_t'($urandom_range(1, 8));
            prod_valid   = ($urandom_range(0, 9) < 7);
            prod_data    = $urandom;
            cons_req     = $urandom_range(0, 1);
            cons_addr    = AW'($urandom_range(0, 9));
            cons_release = ($urandom_range(0, 11) == 0);
            tick();
        end
        idle();

        // Drain everything, then a full-depth fill
        cyc = 0;
        while ((fill_active || full_bank_q.size() > 0) && cyc < 64) begin
            prod_valid = fill_active; prod_data = $urandom;
            cons_release = (full_bank_q.size() > 0);
            tick(); cyc++;
        end
        idle();
        chk("drain_timeout", cyc < 64, 1);
        prod_start = 1'b1; prod_len = DEPTH; tick(); prod_start = 1'b0;
        cyc = 0;
        while (fill_active && cyc < 3 * DEPTH) begin
            prod_valid = ($urandom_range(0, 9) < 8); prod_data = $urandom;
            tick(); cyc++;
        end
        idle();
        chk("depth_fill_timeout", cyc < 3 * DEPTH, 1);
        chk("depth_len", cons_len, DEPTH);
        for (int i = 0; i < 6; i++) begin
            cons_req = 1'b1;
            cons_addr = (i == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        idle(); cons_release = 1'b1; tick(); idle();

        // 6: asynchronous reset mid-fill at count 2
        prod_start = 1'b1; prod_len = 6; tick(); prod_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1; prod_data = $urandom; tick();
        end
        prod_valid = 1'b1; rst_n = 1'b0; #1;
        check_all_zero("async_rst");
        model_reset();
        idle();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        prod_start = 1'b1; prod_len = 3; tick(); prod_start = 1'b0;
        chk("t6_restart_ok", start_err, 0);
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1'b1; prod_data = $urandom; tick();
        end
        idle();
        chk("t6_bank0_full", cons_len, 3);
        cons_req = 1'b1; cons_addr = 2; tick();
        idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
